// File: rtl/alu_pkg.sv
// Shared ALU encodings, forwarding-select constants and the control bundle
// that travels with an instruction through the ID/EX register.
package alu_pkg;

    localparam int W  = 32;
    localparam int RW = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_AND  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_SLL  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_CMP  = 3'd6,
        ALU_RSVD = 3'd7
    } alu_sel_e;

    typedef enum logic [2:0] {
        CMP_EQ    = 3'd0,
        CMP_NE    = 3'd1,
        CMP_LT    = 3'd2,
        CMP_GE    = 3'd3,
        CMP_LTU   = 3'd4,
        CMP_GEU   = 3'd5,
        CMP_RSVD6 = 3'd6,
        CMP_RSVD7 = 3'd7
    } comp_sel_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // ALU controls plus the b-operand source, held together in EX
    typedef struct packed {
        alu_sel_e  alu_sel;
        comp_sel_e comp_sel;
        logic      add_sel;
        logic      arith_sel;
        logic      sign;
        logic      use_imm;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd.sv
// Per-operand forwarding: compares a registered source index against the
// EX/MEM and MEM/WB destinations and picks the freshest value.
module fwd_unit #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [W-1:0]  reg_data,
    input  logic          exmem_wr,
    input  logic [RW-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_z,
    input  logic          memwb_wr,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_data,
    output logic          memwb_hit,
    output logic [W-1:0]  data
);

    import alu_pkg::*;

    logic     exmem_hit;
    fwd_sel_e sel;

    // Register 0 is hardwired, so a write to it must never be forwarded
    assign exmem_hit = exmem_wr && (exmem_rd != '0) && (exmem_rd == idx);
    assign memwb_hit = memwb_wr && (memwb_rd != '0) && (memwb_rd == idx);

    always_comb begin
        sel = FWD_REG;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: data = exmem_z;
            FWD_MEMWB: data = memwb_data;
            default:   data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and
// controls, forwards from EX/MEM and MEM/WB, and supports stall and flush.
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [W-1:0]  rs1_data,
    input  logic [W-1:0]  rs2_data,
    input  logic [RW-1:0] rs1_idx,
    input  logic [RW-1:0] rs2_idx,
    input  logic [RW-1:0] rd_idx,
    input  logic [W-1:0]  imm,
    input  logic          use_imm,
    input  logic [2:0]    alu_sel_in,
    input  logic [2:0]    comp_sel_in,
    input  logic          add_sel_in,
    input  logic          arith_sel_in,
    input  logic          sign_in,
    input  logic          reg_wr_in,
    input  logic          exmem_wr,
    input  logic [RW-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_z,
    input  logic          memwb_wr,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_data,
    output logic          ex_valid,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic          AddSel,
    output logic          ArithSel,
    output logic          sign,
    output logic [2:0]    ALUSel,
    output logic [2:0]    CompSel,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_wr
);

    import alu_pkg::*;

    logic          valid_q;
    logic          reg_wr_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rs1_idx_q;
    logic [RW-1:0] rs2_idx_q;
    logic [W-1:0]  rs1_q;
    logic [W-1:0]  rs2_q;
    logic [W-1:0]  imm_q;
    ctrl_t         ctrl_q;

    logic          rs1_memwb_hit;
    logic          rs2_memwb_hit;
    logic [W-1:0]  rs1_fwd;
    logic [W-1:0]  rs2_fwd;

    // Flush beats stall; during a stall only the operands may change, and
    // only from MEM/WB, so a result retiring under the stall is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            reg_wr_q  <= 1'b0;
            rd_q      <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            reg_wr_q <= 1'b0;
        end else if (stall) begin
            if (rs1_memwb_hit) begin
                rs1_q <= memwb_data;
            end
            if (rs2_memwb_hit) begin
                rs2_q <= memwb_data;
            end
        end else begin
            valid_q          <= in_valid;
            reg_wr_q         <= reg_wr_in & in_valid;
            rd_q             <= rd_idx;
            rs1_idx_q        <= rs1_idx;
            rs2_idx_q        <= rs2_idx;
            rs1_q            <= rs1_data;
            rs2_q            <= rs2_data;
            imm_q            <= imm;
            ctrl_q.alu_sel   <= alu_sel_e'(alu_sel_in);
            ctrl_q.comp_sel  <= comp_sel_e'(comp_sel_in);
            ctrl_q.add_sel   <= add_sel_in;
            ctrl_q.arith_sel <= arith_sel_in;
            ctrl_q.sign      <= sign_in;
            ctrl_q.use_imm   <= use_imm;
        end
    end

    fwd_unit #(.W(W), .RW(RW)) u_fwd_rs1 (
        .idx        (rs1_idx_q),
        .reg_data   (rs1_q),
        .exmem_wr   (exmem_wr),
        .exmem_rd   (exmem_rd),
        .exmem_z    (exmem_z),
        .memwb_wr   (memwb_wr),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .memwb_hit  (rs1_memwb_hit),
        .data       (rs1_fwd)
    );

    fwd_unit #(.W(W), .RW(RW)) u_fwd_rs2 (
        .idx        (rs2_idx_q),
        .reg_data   (rs2_q),
        .exmem_wr   (exmem_wr),
        .exmem_rd   (exmem_rd),
        .exmem_z    (exmem_z),
        .memwb_wr   (memwb_wr),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .memwb_hit  (rs2_memwb_hit),
        .data       (rs2_fwd)
    );

    assign a         = rs1_fwd;
    assign b         = ctrl_q.use_imm ? imm_q : rs2_fwd;
    assign ex_valid  = valid_q;
    assign ex_reg_wr = reg_wr_q & valid_q;
    assign ex_rd     = rd_q;
    assign ALUSel    = ctrl_q.alu_sel;
    assign CompSel   = ctrl_q.comp_sel;
    assign AddSel    = ctrl_q.add_sel;
    assign ArithSel  = ctrl_q.arith_sel;
    assign sign      = ctrl_q.sign;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts each cycle's
// EX outputs, and an independent monitor compares them against the DUT.
module tb_id_ex_stage;

    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, stall, flush;
    logic [W-1:0]  rs1_data, rs2_data, imm;
    logic [RW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic          use_imm;
    logic [2:0]    alu_sel_in, comp_sel_in;
    logic          add_sel_in, arith_sel_in, sign_in, reg_wr_in;
    logic          exmem_wr;
    logic [RW-1:0] exmem_rd;
    logic [W-1:0]  exmem_z;
    logic          memwb_wr;
    logic [RW-1:0] memwb_rd;
    logic [W-1:0]  memwb_data;
    logic          ex_valid;
    logic [W-1:0]  a, b;
    logic          AddSel, ArithSel, sign;
    logic [2:0]    ALUSel, CompSel;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_wr;

    id_ex_stage #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rd_idx(rd_idx), .imm(imm), .use_imm(use_imm), .alu_sel_in(alu_sel_in),
        .comp_sel_in(comp_sel_in), .add_sel_in(add_sel_in), .arith_sel_in(arith_sel_in),
        .sign_in(sign_in), .reg_wr_in(reg_wr_in), .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
        .exmem_z(exmem_z), .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .a(a), .b(b), .AddSel(AddSel), .ArithSel(ArithSel), .sign(sign),
        .ALUSel(ALUSel), .CompSel(CompSel), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          in_valid, stall, flush;
        logic [W-1:0]  rs1_data, rs2_data, imm;
        logic [RW-1:0] rs1_idx, rs2_idx, rd_idx;
        logic          use_imm;
        logic [2:0]    alu_sel, comp_sel;
        logic          add_sel, arith_sel, sign, reg_wr;
        logic          exmem_wr;
        logic [RW-1:0] exmem_rd;
        logic [W-1:0]  exmem_z;
        logic          memwb_wr;
        logic [RW-1:0] memwb_rd;
        logic [W-1:0]  memwb_data;
    } stim_t;

    typedef struct {
        logic          valid, reg_wr;
        logic [W-1:0]  a, b;
        logic [2:0]    alu, comp;
        logic          add, arith, sgn;
        logic [RW-1:0] rd;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];
    stim_t cur;

    // Reference model: what the EX stage is holding, in instruction terms
    logic          m_valid, m_reg_wr;
    stim_t         m_ins;
    logic [W-1:0]  m_d1, m_d2;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t instr(input logic [RW-1:0] i1, input logic [W-1:0] d1,
                                    input logic [RW-1:0] i2, input logic [W-1:0] d2,
                                    input logic [RW-1:0] rd);
        stim_t s;
        s = idle();
        s.in_valid = 1'b1;
        s.reg_wr   = 1'b1;
        s.rs1_idx  = i1;
        s.rs1_data = d1;
        s.rs2_idx  = i2;
        s.rs2_data = d2;
        s.rd_idx   = rd;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.in_valid   = ($urandom_range(0, 3) != 0);
        s.stall      = ($urandom_range(0, 3) == 0);
        s.flush      = ($urandom_range(0, 9) == 0);
        s.rs1_data   = $urandom;
        s.rs2_data   = $urandom;
        s.imm        = $urandom;
        s.rs1_idx    = 5'($urandom_range(0, 3));
        s.rs2_idx    = 5'($urandom_range(0, 3));
        s.rd_idx     = 5'($urandom_range(0, 31));
        s.use_imm    = ($urandom_range(0, 2) == 0);
        s.alu_sel    = 3'($urandom_range(0, 7));
        s.comp_sel   = 3'($urandom_range(0, 7));
        s.add_sel    = ($urandom_range(0, 1) == 1);
        s.arith_sel  = ($urandom_range(0, 1) == 1);
        s.sign       = ($urandom_range(0, 1) == 1);
        s.reg_wr     = ($urandom_range(0, 1) == 1);
        s.exmem_wr   = ($urandom_range(0, 1) == 1);
        s.exmem_rd   = 5'($urandom_range(0, 3));
        s.exmem_z    = $urandom;
        s.memwb_wr   = ($urandom_range(0, 1) == 1);
        s.memwb_rd   = 5'($urandom_range(0, 3));
        s.memwb_data = $urandom;
        return s;
    endfunction

    // Youngest producer wins; register 0 is never a forwarding target
    function automatic logic [W-1:0] fwdModel(input logic [RW-1:0] idx,
                                              input logic [W-1:0] held, input stim_t s);
        if (idx == 0) return held;
        if (s.exmem_wr && s.exmem_rd == idx) return s.exmem_z;
        if (s.memwb_wr && s.memwb_rd == idx) return s.memwb_data;
        return held;
    endfunction

    task automatic modelReset();
        m_valid  = 1'b0;
        m_reg_wr = 1'b0;
        m_ins    = idle();
        m_d1     = '0;
        m_d2     = '0;
    endtask

    task automatic modelClock(input stim_t s);
        if (s.flush) begin
            m_valid  = 1'b0;
            m_reg_wr = 1'b0;
        end else if (s.stall) begin
            if (s.memwb_wr && s.memwb_rd != 0 && s.memwb_rd == m_ins.rs1_idx) m_d1 = s.memwb_data;
            if (s.memwb_wr && s.memwb_rd != 0 && s.memwb_rd == m_ins.rs2_idx) m_d2 = s.memwb_data;
        end else begin
            m_valid  = s.in_valid;
            m_reg_wr = s.in_valid && s.reg_wr;
            m_ins    = s;
            m_d1     = s.rs1_data;
            m_d2     = s.rs2_data;
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, then predict what EX shows during this cycle
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        cur          = s;
        in_valid     = s.in_valid;
        stall        = s.stall;
        flush        = s.flush;
        rs1_data     = s.rs1_data;
        rs2_data     = s.rs2_data;
        imm          = s.imm;
        rs1_idx      = s.rs1_idx;
        rs2_idx      = s.rs2_idx;
        rd_idx       = s.rd_idx;
        use_imm      = s.use_imm;
        alu_sel_in   = s.alu_sel;
        comp_sel_in  = s.comp_sel;
        add_sel_in   = s.add_sel;
        arith_sel_in = s.arith_sel;
        sign_in      = s.sign;
        reg_wr_in    = s.reg_wr;
        exmem_wr     = s.exmem_wr;
        exmem_rd     = s.exmem_rd;
        exmem_z      = s.exmem_z;
        memwb_wr     = s.memwb_wr;
        memwb_rd     = s.memwb_rd;
        memwb_data   = s.memwb_data;
        #2;
        e.valid  = m_valid;
        e.reg_wr = m_valid && m_reg_wr;
        e.a      = fwdModel(m_ins.rs1_idx, m_d1, s);
        e.b      = m_ins.use_imm ? m_ins.imm : fwdModel(m_ins.rs2_idx, m_d2, s);
        e.alu    = m_ins.alu_sel;
        e.comp   = m_ins.comp_sel;
        e.add    = m_ins.add_sel;
        e.arith  = m_ins.arith_sel;
        e.sgn    = m_ins.sign;
        e.rd     = m_ins.rd_idx;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock(cur);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("sb_ex_valid", 32'(ex_valid), 32'(e.valid));
                checkOutput("sb_ex_reg_wr", 32'(ex_reg_wr), 32'(e.reg_wr));
                if (e.valid) begin
                    checkOutput("sb_a", a, e.a);
                    checkOutput("sb_b", b, e.b);
                    checkOutput("sb_ALUSel", 32'(ALUSel), 32'(e.alu));
                    checkOutput("sb_CompSel", 32'(CompSel), 32'(e.comp));
                    checkOutput("sb_AddSel", 32'(AddSel), 32'(e.add));
                    checkOutput("sb_ArithSel", 32'(ArithSel), 32'(e.arith));
                    checkOutput("sb_sign", 32'(sign), 32'(e.sgn));
                    checkOutput("sb_ex_rd", 32'(ex_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        $display("[TB] start");
        rst_n = 1'b0;
        s = idle();
        applyStimulus(s);
        void'(sb.pop_back());
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset_ex_reg_wr", 32'(ex_reg_wr), 32'd0);
        checkOutput("reset_ex_rd", 32'(ex_rd), 32'd0);
        checkOutput("reset_ALUSel", 32'(ALUSel), 32'd0);
        checkOutput("reset_CompSel", 32'(CompSel), 32'd0);
        checkOutput("reset_AddSel", 32'(AddSel), 32'd0);
        checkOutput("reset_ArithSel", 32'(ArithSel), 32'd0);
        checkOutput("reset_sign", 32'(sign), 32'd0);
        checkOutput("reset_a", a, 32'd0);
        checkOutput("reset_b", b, 32'd0);
        rst_n = 1'b1;

        // Basic capture, register then immediate b operand
        s = instr(5'd1, 32'd5, 5'd2, 32'd7, 5'd9);
        applyStimulus(s); tick();
        s = instr(5'd1, 32'd5, 5'd0, 32'd0, 5'd10);
        s.reg_wr = 1'b0; s.use_imm = 1'b1; s.imm = 32'hFFFF_FFFC; s.alu_sel = 3'd1;
        applyStimulus(s);
        checkOutput("capture_a", a, 32'd5);
        checkOutput("capture_b", b, 32'd7);
        checkOutput("capture_valid", 32'(ex_valid), 32'd1);
        checkOutput("capture_rd", 32'(ex_rd), 32'd9);
        checkOutput("capture_reg_wr", 32'(ex_reg_wr), 32'd1);
        tick();
        applyStimulus(idle());
        checkOutput("imm_b", b, 32'hFFFF_FFFC);
        checkOutput("imm_ALUSel", 32'(ALUSel), 32'd1);
        checkOutput("imm_reg_wr", 32'(ex_reg_wr), 32'd0);
        tick();

        // Asynchronous reset with a valid instruction in EX
        s = instr(5'd1, 32'h10, 5'd2, 32'h20, 5'd3);
        s.alu_sel = 3'd3;
        applyStimulus(s); tick();
        s = idle(); s.stall = 1'b1;
        applyStimulus(s);
        checkOutput("pre_reset_valid", 32'(ex_valid), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(ex_valid), 32'd0);
        checkOutput("async_reset_reg_wr", 32'(ex_reg_wr), 32'd0);
        checkOutput("async_reset_ALUSel", 32'(ALUSel), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding priority, plus rs1_idx == rs2_idx and the x0 exclusion
        s = instr(5'd3, 32'h11, 5'd3, 32'h12, 5'd5);
        applyStimulus(s); tick();
        s.exmem_wr = 1'b0; s.exmem_rd = 5'd3; s.exmem_z = 32'hAA;
        s.memwb_wr = 1'b1; s.memwb_rd = 5'd3; s.memwb_data = 32'hBB;
        applyStimulus(s);
        checkOutput("fwd_memwb_a", a, 32'hBB);
        tick();
        s = instr(5'd0, 32'h55, 5'd0, 32'h66, 5'd6);
        s.exmem_wr = 1'b1; s.exmem_rd = 5'd3; s.exmem_z = 32'hAA;
        s.memwb_wr = 1'b1; s.memwb_rd = 5'd3; s.memwb_data = 32'hBB;
        applyStimulus(s);
        checkOutput("fwd_exmem_prio_a", a, 32'hAA);
        checkOutput("fwd_same_idx_b", b, 32'hAA);
        tick();
        s = idle();
        s.exmem_wr = 1'b1; s.exmem_rd = 5'd0; s.exmem_z = 32'hAA;
        s.memwb_wr = 1'b1; s.memwb_rd = 5'd0; s.memwb_data = 32'hBB;
        applyStimulus(s);
        checkOutput("fwd_x0_a", a, 32'h55);
        checkOutput("fwd_x0_b", b, 32'h66);
        tick();

        // MEM/WB value retiring during a stall is kept in the held operand
        s = instr(5'd1, 32'h1, 5'd4, 32'h99, 5'd7);
        applyStimulus(s); tick();
        s = instr(5'd2, 32'h2, 5'd4, 32'hDEAD, 5'd8);
        s.stall = 1'b1; s.memwb_wr = 1'b1; s.memwb_rd = 5'd4; s.memwb_data = 32'h1234;
        applyStimulus(s);
        checkOutput("stall_fwd_b", b, 32'h1234);
        tick();
        s = idle(); s.stall = 1'b1;
        applyStimulus(s);
        checkOutput("stall_held_b", b, 32'h1234);
        checkOutput("stall_held_valid", 32'(ex_valid), 32'd1);
        tick();
        applyStimulus(idle());
        checkOutput("stall_release_b", b, 32'h1234);
        checkOutput("stall_release_rd", 32'(ex_rd), 32'd7);
        tick();

        // Flush wins over stall, then normal capture resumes
        s = instr(5'd1, 32'h3, 5'd2, 32'h4, 5'd7);
        s.stall = 1'b1; s.flush = 1'b1;
        applyStimulus(s); tick();
        s = instr(5'd2, 32'h777, 5'd1, 32'h0, 5'd8);
        applyStimulus(s);
        checkOutput("flush_valid", 32'(ex_valid), 32'd0);
        checkOutput("flush_reg_wr", 32'(ex_reg_wr), 32'd0);
        tick();
        applyStimulus(idle());
        checkOutput("post_flush_valid", 32'(ex_valid), 32'd1);
        checkOutput("post_flush_a", a, 32'h777);
        checkOutput("post_flush_rd", 32'(ex_rd), 32'd8);
        tick();

        // Back-to-back stream with alternating controls
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                s = instr(5'd1, 32'(i), 5'd2, 32'(i + 100), 5'(i + 12));
                s.add_sel = (i % 2 == 1);
                s.alu_sel = (i % 2 == 1) ? 3'd6 : 3'd5;
            end else begin
                s = idle();
            end
            applyStimulus(s);
            if (i > 0) begin
                checkOutput("stream_valid", 32'(ex_valid), 32'd1);
                checkOutput("stream_AddSel", 32'(AddSel), 32'((i - 1) % 2));
                checkOutput("stream_ALUSel", 32'(ALUSel), ((i - 1) % 2 == 1) ? 32'd6 : 32'd5);
                checkOutput("stream_a", a, 32'(i - 1));
            end
            tick();
        end

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(randStim());
            tick();
        end

        applyStimulus(idle());
        tick();
        @(negedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
